// File: rtl/march_ctrl.sv
// March C- BIST sequencer: drives the address generator and RAM strobes, checks read data.
// Optional BIST_STOP_ON_FAIL_EN: the first miscompare aborts the run straight to DONE.
module march_ctrl #(
  parameter int Adr_size  = 4,
  parameter int Data_size = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 done,
  output logic                 fail,
  output logic [Adr_size-1:0]  fail_adr,
  output logic [2:0]           fail_elem,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [Data_size-1:0] mem_din,
  input  logic [Data_size-1:0] mem_dout,
  output logic                 gen_rst_adr,
  output logic                 gen_pr_res_adr,
  output logic                 gen_enable,
  output logic                 gen_up_down,
  input  logic                 gen_c_out,
  input  logic [Adr_size-1:0]  gen_adress
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    OP1,
    OP2,
    FLUSH,
    DONE
  } state_t;

  state_t state, state_nxt;
  logic [2:0] elem, elem_nxt;

  logic                 rd_vld;
  logic [Data_size-1:0] rd_exp;
  logic [Adr_size-1:0]  rd_adr;
  logic [2:0]           rd_elem;

  logic down, single, wr_one, rd_one;
  logic last_op, clr, set_fail, miscmp;

  // E3/E4 walk downwards; E0/E5 have one op per address
  assign down   = (elem == 3'd3) || (elem == 3'd4);
  assign single = (elem == 3'd0) || (elem == 3'd5);
  assign wr_one = (elem == 3'd1) || (elem == 3'd3);
  assign rd_one = (elem == 3'd2) || (elem == 3'd4);
  assign miscmp = (mem_dout != rd_exp);

  always_comb begin
    state_nxt      = state;
    elem_nxt       = elem;
    clr            = 1'b0;
    last_op        = 1'b0;
    done           = 1'b0;
    mem_we         = 1'b0;
    mem_re         = 1'b0;
    mem_din        = '0;
    gen_rst_adr    = 1'b0;
    gen_pr_res_adr = 1'b0;
    gen_enable     = 1'b0;
    gen_up_down    = 1'b1;
    unique case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          clr       = 1'b1;
          elem_nxt  = 3'd0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        gen_up_down    = ~down;
        gen_rst_adr    = ~down;
        gen_pr_res_adr = down;
        state_nxt      = OP1;
      end
      OP1: begin
        gen_up_down = ~down;
        if (elem == 3'd0) mem_we = 1'b1;
        else mem_re = 1'b1;
        if (single) last_op = 1'b1;
        else state_nxt = OP2;
      end
      OP2: begin
        gen_up_down = ~down;
        mem_we      = 1'b1;
        mem_din     = wr_one ? '1 : '0;
        last_op     = 1'b1;
      end
      FLUSH: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase

    if (last_op) begin
      if (!gen_c_out) begin
        gen_enable = 1'b1;
        state_nxt  = OP1;
      end else if (elem == 3'd5) begin
        state_nxt = FLUSH;
      end else begin
        elem_nxt  = 3'(elem + 3'd1);
        state_nxt = LOAD;
      end
    end

    set_fail = rd_vld & miscmp & ~fail & ~clr;
`ifdef BIST_STOP_ON_FAIL_EN
    if (set_fail) state_nxt = DONE;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      elem  <= 3'd0;
    end else begin
      state <= state_nxt;
      elem  <= elem_nxt;
    end
  end

  // read issued now is compared against mem_dout next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld  <= 1'b0;
      rd_exp  <= '0;
      rd_adr  <= '0;
      rd_elem <= 3'd0;
    end else begin
      rd_vld  <= mem_re;
      rd_exp  <= rd_one ? '1 : '0;
      rd_adr  <= gen_adress;
      rd_elem <= elem;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail      <= 1'b0;
      fail_adr  <= '0;
      fail_elem <= 3'd0;
    end else if (clr) begin
      fail      <= 1'b0;
      fail_adr  <= '0;
      fail_elem <= 3'd0;
    end else if (set_fail) begin
      fail      <= 1'b1;
      fail_adr  <= rd_adr;
      fail_elem <= rd_elem;
    end
  end

endmodule

// File: doc/march_ctrl.md
# march_ctrl

BIST controller that runs a March C- test on a synchronous single-port RAM by sequencing the BIST address generator (`Gen`). It drives the generator's reset/preset/enable/direction inputs and uses its terminal-count flag. It also issues RAM read/write strobes with background data and compares read data against expected values. It reports pass/fail and the first failing address and March element.

## Interface
Parameters:
- `Adr_size`, 4, address width; must match `Gen` (N = 2^Adr_size words)
- `Data_size`, 8, RAM word width

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin test; sampled in IDLE and DONE only
- `done`  out  1  test finished; held high in DONE
- `fail`  out  1  sticky miscompare flag
- `fail_adr`  out  Adr_size  address of first miscompare
- `fail_elem`  out  3  March element (0–5) of first miscompare
- `mem_we`  out  1  RAM write strobe
- `mem_re`  out  1  RAM read strobe
- `mem_din`  out  Data_size  write data: all-0 or all-1
- `mem_dout`  in  Data_size  RAM read data; valid the cycle after `mem_re`
- `gen_rst_adr`  out  1  to `Gen.rst_adr`: synchronous load of address 0
- `gen_pr_res_adr`  out  1  to `Gen.pr_res_adr`: synchronous load of all-ones
- `gen_enable`  out  1  to `Gen.enable`
- `gen_up_down`  out  1  to `Gen.up_down`: 1 = increment, 0 = decrement
- `gen_c_out`  in  1  from `Gen.c_out`: address at terminal for current direction (all-ones when up, 0 when down)
- `gen_adress`  in  Adr_size  from `Gen.adress`; the RAM address

## Operation
- Elements, in order:
  - E0 ⇑ w0
  - E1 ⇑ r0,w1
  - E2 ⇑ r1,w0
  - E3 ⇓ r0,w1
  - E4 ⇓ r1,w0
  - E5 ⇑ r0
- FSM states: IDLE, LOAD, OP1, OP2, FLUSH, DONE.
- IDLE/DONE + `start` → LOAD with element 0. Entering LOAD from IDLE/DONE clears `fail`, `fail_adr`, `fail_elem`, `done`.
- LOAD (1 cycle) → OP1:
  - up element: `gen_rst_adr`=1, `gen_up_down`=1
  - down element: `gen_pr_res_adr`=1, `gen_up_down`=0
- OP1 performs the first operation at `gen_adress`:
  - w0 (E0): `mem_we`=1, `mem_din`=0
  - read (E1–E5): `mem_re`=1
- OP2 (E1–E4 only) performs the write: `mem_we`=1, `mem_din`=all-1 for E1/E3, 0 for E2/E4.
- Last op cycle of an address (OP1 for E0/E5, OP2 otherwise):
  - `gen_c_out`=0: `gen_enable`=1 and return to OP1.
  - `gen_c_out`=1: `gen_enable`=0; go to LOAD of the next element, or to FLUSH after E5.
- `gen_up_down` is held at the element's direction through LOAD/OP1/OP2.
- Compare pipeline:
  - On each read, register the expected value (0 for E1/E3/E5, all-1 for E2/E4), `gen_adress`, and the element index.
  - Next cycle, compare against `mem_dout`.
  - On mismatch with `fail`=0: set `fail`, capture `fail_adr` and `fail_elem`.
  - Later mismatches do not overwrite the capture.
- FLUSH (1 cycle): final E5 compare → DONE.
- DONE: `done`=1; all strobes 0.
- `start` during LOAD/OP1/OP2/FLUSH is ignored.
- All `gen_*` and `mem_*` outputs are registered-state decodes; no combinational path from `mem_dout` to them.

## Timing
- Reset values: state=IDLE; `done`=0, `fail`=0, `fail_adr`=0, `fail_elem`=0. All strobes and `gen_*` outputs are 0, except `gen_up_down`, which is 1.
- `rst` mid-test: immediate return to IDLE; the RAM contents and `Gen` address are left as-is. The next `start` reloads via LOAD.
- `start` seen at edge k → LOAD at cycle k+1.
- Run length: LOAD through last op is 10N+6 cycles (6 LOAD, N for E0, 2N each for E1–E4, N for E5).
  - Then FLUSH: 1 cycle.
  - DONE is entered 10N+7 cycles after the first LOAD (167 for N=16).
- Address wrap is never used: every element terminates on `gen_c_out`.

## Configuration
- `BIST_STOP_ON_FAIL_EN` defined: the compare cycle that sets `fail` forces the next state to DONE, aborting the run. Strobes that cycle still follow the current state.
- Not defined: a miscompare only records `fail` and the capture; the run always completes the full 10N+7 cycles.

## Test plan
- Fault-free RAM, N=16, `start` pulse → `done` 167 cycles after first LOAD, `fail`=0; E0 writes addresses 0..15 in order, E3 visits 15..0.
- Stuck-at-0 on bit 3 at address 5 → `fail`=1, `fail_adr`=5, `fail_elem`=2; completes in 167 cycles without the macro.
- Stuck-at-1 on bit 0 at address 0 → `fail_adr`=0, `fail_elem`=1. With `BIST_STOP_ON_FAIL_EN`, `done` rises within 2 cycles of that read.
- Two faults, at addresses 3 and 9, both failing in E1 → capture holds `fail_adr`=3, `fail_elem`=1.
- `rst` asserted mid-E2 → all outputs at reset values at once. A new `start` runs a clean 167-cycle pass with `fail`=0.
- `start` held during a run → no effect. `start` in DONE after a failing run → `fail` cleared and the test reruns.
